// File: rtl/uart_tx_if.sv
// Byte handshake between a bus master and the UART transmitter FIFO.
// Latency: none; these are plain wires. A byte moves on a rising edge where valid && ready.
// Backpressure: the transmitter drops ready while its FIFO is full.
//   valid : master has a byte on data
//   data  : byte to transmit
//   ready : transmitter can accept a byte this cycle
interface uart_tx_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: queues bytes in a small FIFO and serialises them on tx as 8N1 frames.
// Latency: a byte accepted at edge E into an idle, empty block puts the start bit on tx from edge E+1.
// Backpressure: host.ready (registered) is low while the FIFO holds FIFO_DEPTH bytes.
//   clk    : system clock, rising edge
//   resetn : synchronous active-low reset
//   host   : valid/data/ready byte handshake (uart_tx_if.slave)
//   tx     : serial line, idle high, driven from a flop
//   busy   : a frame is in progress or bytes are still queued
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx #(
  parameter int CLOCK_HZ   = 10,
  parameter int BAUD_RATE  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     resetn,
  uart_tx_if.slave host,
  output logic     tx,
  output logic     busy
);

  // CLOCKS_PER_BAUD must be at least 2 and FIFO_DEPTH a power of two >= 2.
  localparam int CPB   = CLOCK_HZ / BAUD_RATE;
  localparam int CNT_W = $clog2(CPB);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPB - 1);

`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  logic [2:0] state, state_n;
`else
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
  logic [1:0] state, state_n;
`endif

  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tick;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n;

  // FIFO storage and bookkeeping; pointers wrap naturally at FIFO_DEPTH.
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_n;
  logic             ready_q;
  logic             push, pop;

  assign host.ready = ready_q;
  assign push       = host.valid && ready_q;
  assign tick       = (cnt == CNT_MAX);
  assign busy       = (state != S_IDLE) || (count != '0);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;

    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_n = S_DATA;
          idx_n   = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx != 3'd7) begin
            idx_n = idx + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        // A queued byte starts immediately after the stop bit, with no idle gap.
        if (tick) begin
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // The counter restarts on every state entry and on every bit boundary.
    if (state_n != state || state == S_IDLE || tick) cnt_n = '0;
    else                                              cnt_n = cnt + CNT_W'(1);

    // tx is computed from the next state so the line changes on the same edge as the state.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[idx_n];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_n = ^shift_n;
`endif
      default:  tx_n = 1'b1;
    endcase

    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
      count   <= count_n;
      ready_q <= (count_n < CW'(FIFO_DEPTH));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push) mem[wr_ptr] <= host.data;
  end

endmodule
